nonogram_input_ctrl: RTL and testbench

Player-side front end of the nonogram board. It consumes one-cycle key pulses, moves a cursor over the 10x10 grid, and edits per-cell paint/block marks. It exports the paint and block grid vectors that nonogram_game reads for level-clear checking. It also counts wrong paints against the loaded solution and flags when the painted grid equals the solution.

---
 rtl/nonogram_pkg.sv | 29 ++
 rtl/nonogram_cursor.sv | 50 +++++
 rtl/nonogram_input_ctrl.sv | 106 ++++++++++
 tb/tb_nonogram_input_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nonogram_pkg.sv
// Shared nonogram player-side definitions: grid size, key strobe bit positions, cell encoding.
// Latency: none (types, constants and a pure index function).
// Backpressure: not applicable; key strobes are fire-and-forget one-cycle pulses.
package nonogram_pkg;

  localparam int GRID_N = 10;

  // Bit positions inside key_pulse
  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_ACT   = 4;

  // Cell state as {paint, block}; 2'b11 is never produced
  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_BLOCK = 2'b01,
    CELL_PAINT = 2'b10
  } cell_e;

  // Row 0 sits in the MSBs and x=0 is the MSB of its row, so row-concatenated
  // solution literals read left-to-right, top-to-bottom.
  function automatic int unsigned cell_idx(input logic [3:0] x, input logic [3:0] y,
                                           input int unsigned n);
    return n * n - 1 - (n * 32'(y) + 32'(x));
  endfunction

endpackage

// File: rtl/nonogram_cursor.sv
// Wrapping x/y cursor over the grid, driven by priority-decoded move strobes.
// Latency: a move is visible on the clock edge of its strobe; clear returns to (0,0) on the same edge.
// Backpressure: none; at most one move is taken per cycle (up > down > left > right), others dropped.
module nonogram_cursor #(
  parameter int GRID_N = nonogram_pkg::GRID_N
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [3:0] mv,
  output logic [3:0] sel_x,
  output logic [3:0] sel_y
);
  import nonogram_pkg::*;

  localparam logic [3:0] POS_MAX = 4'(GRID_N - 1);

  logic [3:0] x_nxt;
  logic [3:0] y_nxt;

  // Next cursor position: clear first, then one move by priority, both axes wrapping
  always_comb begin
    x_nxt = sel_x;
    y_nxt = sel_y;
    if (clear) begin
      x_nxt = '0;
      y_nxt = '0;
    end else if (mv[KEY_UP]) begin
      y_nxt = (sel_y == 4'd0) ? POS_MAX : sel_y - 4'd1;
    end else if (mv[KEY_DOWN]) begin
      y_nxt = (sel_y == POS_MAX) ? 4'd0 : sel_y + 4'd1;
    end else if (mv[KEY_LEFT]) begin
      x_nxt = (sel_x == 4'd0) ? POS_MAX : sel_x - 4'd1;
    end else if (mv[KEY_RIGHT]) begin
      x_nxt = (sel_x == POS_MAX) ? 4'd0 : sel_x + 4'd1;
    end
  end

  // Cursor registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_x <= '0;
      sel_y <= '0;
    end else begin
      sel_x <= x_nxt;
      sel_y <= y_nxt;
    end
  end

endmodule

// File: rtl/nonogram_input_ctrl.sv
// Player front end: cursor movement, per-cell paint/block editing, wrong-paint count, solved flag.
// Latency: grid/cursor update on the key edge; event_off and board_clear are registered off next-state.
// Backpressure: none; one key per cycle by priority (action > up > down > left > right), lock drops all keys.
module nonogram_input_ctrl #(
  parameter int GRID_N  = nonogram_pkg::GRID_N,
  parameter int WRONG_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [4:0]                 key_pulse,
  input  logic [GRID_N*GRID_N-1:0]   solution,
  input  logic                       clear_board,
  input  logic                       lock,
  output logic [3:0]                 sel_x,
  output logic [3:0]                 sel_y,
  output logic [GRID_N*GRID_N-1:0]   paint,
  output logic [GRID_N*GRID_N-1:0]   block,
  output logic                       event_off,
  output logic [WRONG_W-1:0]         wrong_count,
  output logic                       board_clear
);
  import nonogram_pkg::*;

  localparam int                 CELLS     = GRID_N * GRID_N;
  localparam int                 IDX_W     = $clog2(CELLS);
  localparam logic [WRONG_W-1:0] WRONG_MAX = {WRONG_W{1'b1}};

  logic               act;
  logic [3:0]         mv;
  logic [IDX_W-1:0]   idx;
  cell_e              cur_cell;
  logic [CELLS-1:0]   paint_nxt;
  logic [CELLS-1:0]   block_nxt;
  logic [WRONG_W-1:0] wrong_nxt;

  // Key gating: lock drops everything, action suppresses any same-cycle move
  always_comb begin
    act = !lock && key_pulse[KEY_ACT];
    mv  = (lock || key_pulse[KEY_ACT]) ? 4'b0000 : key_pulse[3:0];
  end

  nonogram_cursor #(
    .GRID_N (GRID_N)
  ) u_cursor (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_board),
    .mv    (mv),
    .sel_x (sel_x),
    .sel_y (sel_y)
  );

  // Cell under the cursor and its current state
  always_comb begin
    idx      = IDX_W'(cell_idx(sel_x, sel_y, GRID_N));
    cur_cell = cell_e'({paint[idx], block[idx]});
  end

  // Next grid and counter: clear wins, otherwise action steps EMPTY -> PAINT -> BLOCK -> EMPTY
  always_comb begin
    paint_nxt = paint;
    block_nxt = block;
    wrong_nxt = wrong_count;
    if (clear_board) begin
      paint_nxt = '0;
      block_nxt = '0;
      wrong_nxt = '0;
    end else if (act) begin
      case (cur_cell)
        CELL_EMPTY: begin
          paint_nxt[idx] = 1'b1;
          if (!solution[idx] && wrong_count != WRONG_MAX) begin
            wrong_nxt = wrong_count + 1'b1;
          end
        end
        CELL_PAINT: begin
          paint_nxt[idx] = 1'b0;
          block_nxt[idx] = 1'b1;
        end
        default: begin
          // BLOCK, and the unreachable {1,1}, both fall back to EMPTY
          paint_nxt[idx] = 1'b0;
          block_nxt[idx] = 1'b0;
        end
      endcase
    end
  end

  // Grid, counter, change pulse and solved flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      paint       <= '0;
      block       <= '0;
      wrong_count <= '0;
      event_off   <= 1'b0;
      board_clear <= 1'b0;
    end else begin
      paint       <= paint_nxt;
      block       <= block_nxt;
      wrong_count <= wrong_nxt;
      event_off   <= (paint_nxt != paint) || (block_nxt != block);
      board_clear <= (paint_nxt == solution);
    end
  end

endmodule

// File: tb/tb_nonogram_input_ctrl.sv
module tb_nonogram_input_ctrl;
  localparam int N = 10;
  localparam int C = N * N;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   key_pulse;
  logic [C-1:0] solution;
  logic         clear_board;
  logic         lock;
  logic [3:0]   sel_x;
  logic [3:0]   sel_y;
  logic [C-1:0] paint;
  logic [C-1:0] block;
  logic         event_off;
  logic [4:0]   wrong_count;
  logic         board_clear;

  nonogram_input_ctrl #(.GRID_N(N), .WRONG_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_pulse   (key_pulse),
    .solution    (solution),
    .clear_board (clear_board),
    .lock        (lock),
    .sel_x       (sel_x),
    .sel_y       (sel_y),
    .paint       (paint),
    .block       (block),
    .event_off   (event_off),
    .wrong_count (wrong_count),
    .board_clear (board_clear)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: cells numbered row-major n = y*N + x
  bit mp[C];
  bit mb[C];
  int mx, my, mwrong;
  bit mev;

  localparam logic [4:0] K_UP = 5'b00001, K_DN = 5'b00010, K_LT = 5'b00100,
                         K_RT = 5'b01000, K_ACT = 5'b10000, K_NONE = 5'b00000;

  function automatic logic [C-1:0] model_paint();
    logic [C-1:0] v;
    v = '0;
    for (int n = 0; n < C; n++) v[C-1-n] = mp[n];
    return v;
  endfunction

  function automatic logic [C-1:0] model_block();
    logic [C-1:0] v;
    v = '0;
    for (int n = 0; n < C; n++) v[C-1-n] = mb[n];
    return v;
  endfunction

  function automatic logic [C-1:0] rand_vec();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[C-1:0];
  endfunction

  task automatic model_reset();
    for (int n = 0; n < C; n++) begin
      mp[n] = 1'b0;
      mb[n] = 1'b0;
    end
    mx = 0; my = 0; mwrong = 0; mev = 1'b0;
  endtask

  // One clock with the given strobes; the model follows the game rules
  task automatic step(input logic [4:0] k, input logic c, input logic l);
    int n;
    bit nonempty;
    @(negedge clk);
    key_pulse = k; clear_board = c; lock = l;
    @(posedge clk);
    #1;
    key_pulse = '0; clear_board = 1'b0; lock = 1'b0;
    mev = 1'b0;
    if (c) begin
      nonempty = 1'b0;
      for (int i = 0; i < C; i++) if (mp[i] || mb[i]) nonempty = 1'b1;
      mev = nonempty;
      for (int i = 0; i < C; i++) begin
        mp[i] = 1'b0;
        mb[i] = 1'b0;
      end
      mwrong = 0; mx = 0; my = 0;
    end else if (!l && k != 5'b0) begin
      if (k[4]) begin
        n = my * N + mx;
        if (!mp[n] && !mb[n]) begin
          mp[n] = 1'b1;
          if (!solution[C-1-n] && mwrong < 31) mwrong++;
        end else if (mp[n]) begin
          mp[n] = 1'b0;
          mb[n] = 1'b1;
        end else begin
          mb[n] = 1'b0;
        end
        mev = 1'b1;
      end else if (k[0]) my = (my + N - 1) % N;
      else if (k[1]) my = (my + 1) % N;
      else if (k[2]) mx = (mx + N - 1) % N;
      else mx = (mx + 1) % N;
    end
  endtask

  task automatic go_to(input int x, input int y);
    while (mx != x) step(K_RT, 1'b0, 1'b0);
    while (my != y) step(K_DN, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0; key_pulse = '0; clear_board = 1'b0; lock = 1'b0;
    solution = rand_vec() | {{(C-1){1'b0}}, 1'b1};
    model_reset();
    repeat (2) @(negedge clk);
    total++; if (sel_x !== 4'd0 || sel_y !== 4'd0) begin bad++; $display("FAIL reset_sel got=(%0d,%0d) exp=(0,0)", sel_x, sel_y); end
    total++; if (paint !== '0) begin bad++; $display("FAIL reset_paint got=%h exp=0", paint); end
    total++; if (block !== '0) begin bad++; $display("FAIL reset_block got=%h exp=0", block); end
    total++; if (wrong_count !== 5'd0) begin bad++; $display("FAIL reset_wrong got=%0d exp=0", wrong_count); end
    total++; if (event_off !== 1'b0) begin bad++; $display("FAIL reset_event got=%b exp=0", event_off); end
    total++; if (board_clear !== 1'b0) begin bad++; $display("FAIL reset_bc got=%b exp=0", board_clear); end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(K_NONE, 1'b0, 1'b0);
      total++; if (board_clear !== 1'b0) begin bad++; $display("FAIL post_reset_bc got=%b exp=0", board_clear); end
    end
  endtask

  task automatic test_wrap();
    step(K_LT, 1'b0, 1'b0);
    total++; if (sel_x !== 4'd9 || event_off !== 1'b0) begin bad++; $display("FAIL wrap_left got x=%0d ev=%b exp x=9 ev=0", sel_x, event_off); end
    step(K_UP, 1'b0, 1'b0);
    total++; if (sel_y !== 4'd9 || event_off !== 1'b0) begin bad++; $display("FAIL wrap_up got y=%0d ev=%b exp y=9 ev=0", sel_y, event_off); end
    step(K_RT, 1'b0, 1'b0);
    total++; if (sel_x !== 4'd0 || sel_y !== 4'd9 || event_off !== 1'b0) begin bad++; $display("FAIL wrap_right got (%0d,%0d) ev=%b exp (0,9) ev=0", sel_x, sel_y, event_off); end
    step(K_DN, 1'b0, 1'b0);
    total++; if (sel_y !== 4'd0) begin bad++; $display("FAIL wrap_down got y=%0d exp 0", sel_y); end
  endtask

  task automatic test_cell_cycle();
    solution = rand_vec();
    solution[87] = 1'b1;
    step(K_NONE, 1'b1, 1'b0);
    go_to(2, 1);
    step(K_ACT, 1'b0, 1'b0);
    total++; if (paint[87] !== 1'b1 || block[87] !== 1'b0 || event_off !== 1'b1) begin bad++; $display("FAIL cycle_paint got p=%b b=%b ev=%b exp 1 0 1", paint[87], block[87], event_off); end
    step(K_NONE, 1'b0, 1'b0);
    total++; if (event_off !== 1'b0) begin bad++; $display("FAIL cycle_pulse_width got ev=%b exp 0", event_off); end
    step(K_ACT, 1'b0, 1'b0);
    total++; if (paint[87] !== 1'b0 || block[87] !== 1'b1 || event_off !== 1'b1) begin bad++; $display("FAIL cycle_block got p=%b b=%b ev=%b exp 0 1 1", paint[87], block[87], event_off); end
    step(K_ACT, 1'b0, 1'b0);
    total++; if (paint[87] !== 1'b0 || block[87] !== 1'b0) begin bad++; $display("FAIL cycle_empty got p=%b b=%b exp 0 0", paint[87], block[87]); end
    total++; if (wrong_count !== 5'd0) begin bad++; $display("FAIL cycle_wrong got=%0d exp=0", wrong_count); end
  endtask

  task automatic test_wrong_sat();
    int e;
    solution[99] = 1'b0;
    step(K_NONE, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(K_ACT, 1'b0, 1'b0);
      e = (i + 1 > 31) ? 31 : i + 1;
      total++; if (wrong_count !== 5'(e)) begin bad++; $display("FAIL wrong_step%0d got=%0d exp=%0d", i, wrong_count, e); end
      step(K_ACT, 1'b0, 1'b0);
      step(K_ACT, 1'b0, 1'b0);
    end
    total++; if (wrong_count !== 5'd31) begin bad++; $display("FAIL wrong_sat got=%0d exp=31", wrong_count); end
  endtask

  task automatic test_clear_lock();
    int last;
    solution = rand_vec() | {1'b1, {(C-1){1'b0}}};
    last = 0;
    for (int n = 0; n < C; n++) if (solution[C-1-n]) last = n;
    step(K_NONE, 1'b1, 1'b0);
    for (int n = 0; n < C; n++) begin
      if (solution[C-1-n]) begin
        step(K_ACT, 1'b0, 1'b0);
        total++; if (board_clear !== (n == last)) begin bad++; $display("FAIL solve_cell%0d got bc=%b exp=%b", n, board_clear, (n == last)); end
      end
      if (n < C - 1) begin
        step(K_RT, 1'b0, 1'b0);
        if (mx == 0) step(K_DN, 1'b0, 1'b0);
      end
    end
    step(K_ACT, 1'b0, 1'b1);
    step(K_RT, 1'b0, 1'b1);
    total++; if (sel_x !== 4'd9 || sel_y !== 4'd9) begin bad++; $display("FAIL lock_sel got=(%0d,%0d) exp=(9,9)", sel_x, sel_y); end
    total++; if (paint !== solution) begin bad++; $display("FAIL lock_paint got=%h exp=%h", paint, solution); end
    total++; if (board_clear !== 1'b1 || event_off !== 1'b0) begin bad++; $display("FAIL lock_bc got bc=%b ev=%b exp 1 0", board_clear, event_off); end
  endtask

  task automatic test_simultaneous();
    step(K_NONE, 1'b1, 1'b0);
    go_to(3, 3);
    step(5'b10001, 1'b0, 1'b0);
    total++; if (paint[66] !== 1'b1 || sel_x !== 4'd3 || sel_y !== 4'd3 || event_off !== 1'b1) begin bad++; $display("FAIL simul_act got p66=%b sel=(%0d,%0d) ev=%b exp 1 (3,3) 1", paint[66], sel_x, sel_y, event_off); end
    step(K_ACT, 1'b1, 1'b0);
    total++; if (paint !== '0 || wrong_count !== 5'd0 || sel_x !== 4'd0 || sel_y !== 4'd0 || event_off !== 1'b1) begin bad++; $display("FAIL simul_clear got paint=%h w=%0d sel=(%0d,%0d) ev=%b", paint, wrong_count, sel_x, sel_y, event_off); end
    step(K_NONE, 1'b0, 1'b0);
    total++; if (event_off !== 1'b0) begin bad++; $display("FAIL simul_pulse got ev=%b exp 0", event_off); end
  endtask

  task automatic test_random();
    logic [4:0] k;
    logic c, l;
    logic [C-1:0] ep;
    solution = rand_vec();
    step(K_NONE, 1'b1, 1'b0);
    for (int i = 0; i < 400; i++) begin
      k = ($urandom_range(0, 9) < 6) ? (5'b00001 << $urandom_range(0, 4)) : 5'($urandom);
      c = ($urandom_range(0, 29) == 0);
      l = ($urandom_range(0, 9) == 0);
      step(k, c, l);
      ep = model_paint();
      total++; if (sel_x !== 4'(mx) || sel_y !== 4'(my)) begin bad++; $display("FAIL rnd%0d_sel got=(%0d,%0d) exp=(%0d,%0d)", i, sel_x, sel_y, mx, my); end
      total++; if (paint !== ep) begin bad++; $display("FAIL rnd%0d_paint got=%h exp=%h", i, paint, ep); end
      total++; if (block !== model_block()) begin bad++; $display("FAIL rnd%0d_block got=%h exp=%h", i, block, model_block()); end
      total++; if (wrong_count !== 5'(mwrong)) begin bad++; $display("FAIL rnd%0d_wrong got=%0d exp=%0d", i, wrong_count, mwrong); end
      total++; if (event_off !== mev) begin bad++; $display("FAIL rnd%0d_event got=%b exp=%b", i, event_off, mev); end
      total++; if (board_clear !== (ep == solution)) begin bad++; $display("FAIL rnd%0d_bc got=%b exp=%b", i, board_clear, (ep == solution)); end
    end
  endtask

  task automatic test_reset_mid();
    step(K_NONE, 1'b1, 1'b0);
    step(K_RT, 1'b0, 1'b0);
    step(K_ACT, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    total++; if (event_off !== 1'b0 || paint !== '0 || block !== '0 || sel_x !== 4'd0 || sel_y !== 4'd0) begin bad++; $display("FAIL reset_mid got ev=%b paint=%h sel=(%0d,%0d)", event_off, paint, sel_x, sel_y); end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    step(K_NONE, 1'b0, 1'b0);
    total++; if (event_off !== 1'b0) begin bad++; $display("FAIL reset_mid_pending got ev=%b exp 0", event_off); end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_cell_cycle();
    test_wrong_sat();
    test_clear_lock();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
